// File: rtl/lsu_dmem_port.sv
// lsu_dmem_port: byte/half/word load-store unit between the CPU mem stage and dmem; define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses instead of rejecting misaligned ones.
module lsu_dmem_port #(
  parameter int xlen = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_v,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [xlen-1:0] req_adr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [xlen-1:0] req_wdata,
  output logic            resp_v,
  output logic [xlen-1:0] resp_data,
  output logic            misalign_err,
  output logic            r_v,
  output logic            w_v,
  output logic [xlen-1:0] data_adr,
  output logic [xlen-1:0] data_o,
  output logic [3:0]      strobe,
  input  logic [xlen-1:0] dmem_resp,
  input  logic            dmem_resp_v
);
`ifdef LSU_MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {IDLE, ACCESS, ACCESS2, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif
  state_t state, state_nx;
  logic [xlen-1:0] adr_q, wdata_q, ld, ext;
  logic [1:0] size_q;
  logic we_q, uns_q, mis, busy, last, accept;
  logic [3:0] mask;
  logic [4:0] sh;
  assign accept = state == IDLE && req_v;
  assign req_ready = state == IDLE;
  assign resp_v = state == RESP;
  assign r_v = busy & ~we_q;
  assign w_v = busy & we_q;
  assign mask = size_q == 2'd0 ? 4'b0001 : size_q == 2'd1 ? 4'b0011 : 4'b1111;
  assign sh = {adr_q[1:0], 3'b000};
  assign ext = size_q == 2'd0 ? {{24{~uns_q & ld[7]}}, ld[7:0]} :
               size_q == 2'd1 ? {{16{~uns_q & ld[15]}}, ld[15:0]} : ld;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [7:0] lanes;
  logic [xlen-1:0] buf_q;
  logic split;
  assign mis = 1'b0;
  // Upper nibble of the shifted mask holds the lanes that spill into the next word.
  assign lanes = {4'b0000, mask} << adr_q[1:0];
  assign split = |lanes[7:4];
  assign busy = state == ACCESS || state == ACCESS2;
  assign last = state == ACCESS2 || (state == ACCESS && !split);
  assign ld = xlen'((state == ACCESS2 ? {dmem_resp, buf_q} : {{xlen{1'b0}}, dmem_resp}) >> sh);
  assign data_adr = busy ? {adr_q[xlen-1:2], 2'b00} + (state == ACCESS2 ? xlen'(4) : xlen'(0)) : '0;
  assign strobe = state == ACCESS ? lanes[3:0] : state == ACCESS2 ? lanes[7:4] : 4'b0000;
  assign data_o = busy ? (wdata_q << sh) | (wdata_q >> (6'd32 - {1'b0, sh})) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) buf_q <= '0;
    else if (state == ACCESS && dmem_resp_v) buf_q <= dmem_resp;
`else
  assign mis = (req_size == 2'd1 && req_adr[0]) || (req_size[1] && req_adr[1:0] != 2'b00);
  assign busy = state == ACCESS;
  assign last = busy;
  assign ld = dmem_resp >> sh;
  assign data_adr = busy ? {adr_q[xlen-1:2], 2'b00} : '0;
  assign strobe = busy ? mask << adr_q[1:0] : 4'b0000;
  assign data_o = !busy ? '0 : size_q == 2'd0 ? {4{wdata_q[7:0]}} :
                  size_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_v ? (mis ? RESP : ACCESS) : IDLE;
`ifdef LSU_MISALIGNED_SPLIT_EN
      ACCESS:  state_nx = !dmem_resp_v ? ACCESS : split ? ACCESS2 : RESP;
      ACCESS2: state_nx = dmem_resp_v ? RESP : ACCESS2;
`else
      ACCESS:  state_nx = dmem_resp_v ? RESP : ACCESS;
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      adr_q <= '0;
      wdata_q <= '0;
      size_q <= 2'd0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      resp_data <= '0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        adr_q <= req_adr;
        wdata_q <= req_wdata;
        size_q <= req_size;
        we_q <= req_we;
        uns_q <= req_unsigned;
        misalign_err <= mis;
      end
      if (last && dmem_resp_v) resp_data <= we_q ? '0 : ext;
      if (resp_v) begin
        resp_data <= '0;
        misalign_err <= 1'b0;
      end
    end
endmodule

// File: tb/tb_lsu_dmem_port.sv
// tb_lsu_dmem_port: randomized scoreboard bench for lsu_dmem_port against a byte-addressed memory model.
module tb_lsu_dmem_port;
  logic clk = 1'b0, rst_n = 1'b0, req_v = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_adr = 32'h0, req_wdata = 32'h0;
  logic [1:0] req_size = 2'd0;
  logic req_ready, resp_v, misalign_err, r_v, w_v, dmem_resp_v;
  logic [31:0] resp_data, data_adr, data_o, dmem_resp;
  logic [3:0] strobe;

  typedef struct {logic [31:0] adr; logic [3:0] strb; logic we; logic [31:0] dat; logic [31:0] dmask;} beat_t;
  typedef struct {logic err; logic [31:0] data;} resp_t;
  beat_t exp_beat[$];
  resp_t exp_resp[$];
  logic [7:0] ref_mem [1024];
  logic [31:0] dm [256];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, exp_busy = 0, force_delay = -1;
  bit hold_ack = 1'b0, spurious = 1'b0;

  lsu_dmem_port #(.xlen(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_v(req_v), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_v(resp_v), .resp_data(resp_data), .misalign_err(misalign_err), .r_v(r_v), .w_v(w_v),
    .data_adr(data_adr), .data_o(data_o), .strobe(strobe), .dmem_resp(dmem_resp),
    .dmem_resp_v(dmem_resp_v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_quiet(string tag);
    check({tag, " bus ctl"}, {26'h0, r_v, w_v, strobe}, 32'h0);
    check({tag, " data_adr"}, data_adr, 32'h0);
    check({tag, " data_o"}, data_o, 32'h0);
    check({tag, " resp flags"}, {30'h0, resp_v, misalign_err}, 32'h0);
    check({tag, " resp_data"}, resp_data, 32'h0);
  endtask

  task automatic poke(int w, logic [31:0] v);
    dm[w] = v;
    for (int i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] extend(int n, bit u, logic [31:0] v);
    if (n == 1) return u ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (n == 2) return u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Present a request, hold it until accepted, and record what the bus and response must look like.
  task automatic issue(bit we, logic [31:0] a, logic [1:0] sz, bit u, logic [31:0] wd);
    int n, t;
    bit mis;
    beat_t b0, b1;
    logic [31:0] ld;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
`ifdef LSU_MISALIGNED_SPLIT_EN
    mis = 1'b0;
`else
    mis = (a % n) != 0;
`endif
    req_v = 1'b1; req_we = we; req_adr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept timeout: req_ready 0, required 1");
      req_v = 1'b0;
      return;
    end
    b0 = '{a & ~32'd3, 4'h0, we, 32'h0, 32'h0};
    b1 = '{(a & ~32'd3) + 32'd4, 4'h0, we, 32'h0, 32'h0};
    ld = 32'h0;
    for (int i = 0; i < n; i++) begin
      int ba, ln;
      logic [7:0] v;
      ba = int'(a) + i;
      ln = ba % 4;
      v = wd[8*i +: 8];
      if (!mis) begin
        if ((ba >> 2) == int'(a >> 2)) begin
          b0.strb[ln] = 1'b1; b0.dat[8*ln +: 8] = v; b0.dmask[8*ln +: 8] = we ? 8'hFF : 8'h00;
        end else begin
          b1.strb[ln] = 1'b1; b1.dat[8*ln +: 8] = v; b1.dmask[8*ln +: 8] = we ? 8'hFF : 8'h00;
        end
        if (we) ref_mem[ba] = v;
        else ld[8*i +: 8] = ref_mem[ba];
      end
    end
`ifndef LSU_MISALIGNED_SPLIT_EN
    if (we) begin
      b0.dat = n == 1 ? {4{wd[7:0]}} : n == 2 ? {2{wd[15:0]}} : wd;
      b0.dmask = 32'hFFFFFFFF;
    end
`endif
    if (mis) exp_resp.push_back('{1'b1, 32'h0});
    else begin
      exp_beat.push_back(b0);
      if (b1.strb != 4'h0) exp_beat.push_back(b1);
      exp_resp.push_back('{1'b0, we ? 32'h0 : extend(n, u, ld)});
    end
    acc_cyc = cyc;
    exp_busy = 0;
    @(negedge clk);
    req_v = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_resp.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_resp.size() != 0) begin
      errors++;
      $display("FAIL drain timeout: %0d responses outstanding, required 0", exp_resp.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // dmem model: random ack delay, checks each beat against the expected queue and holds it stable.
  initial begin : responder
    beat_t got, e;
    int d;
    dmem_resp_v = 1'b0;
    dmem_resp = 32'h0;
    forever begin
      @(negedge clk);
      dmem_resp_v = spurious;
      dmem_resp = spurious ? 32'hA5A5A5A5 : 32'h0;
      if (rst_n && (r_v || w_v)) begin
        got = '{data_adr, strobe, w_v, data_o, 32'h0};
        d = force_delay >= 0 ? force_delay : int'($urandom_range(0, 2));
        if (exp_beat.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected beat: adr %h strobe %b, required none", data_adr, strobe);
        end else begin
          e = exp_beat.pop_front();
          check("beat adr", got.adr, e.adr);
          check("beat strobe", {28'h0, got.strb}, {28'h0, e.strb});
          check("beat w_v", {31'h0, w_v}, {31'h0, e.we});
          check("beat r_v", {31'h0, r_v}, {31'h0, !e.we});
          check("beat data_o", got.dat & e.dmask, e.dat & e.dmask);
        end
        for (int k = 0; (k < d || hold_ack) && rst_n; k++) begin
          @(negedge clk);
          if (rst_n) begin
            checks++;
            if ({data_adr, data_o, strobe, w_v, r_v} !== {got.adr, got.dat, got.strb, got.we, !got.we}) begin
              errors++;
              $display("FAIL held beat: adr %h strobe %b data %h, required adr %h strobe %b data %h",
                       data_adr, strobe, data_o, got.adr, got.strb, got.dat);
            end
          end
        end
        if (rst_n) begin
          dmem_resp_v = 1'b1;
          dmem_resp = dm[data_adr[9:2]];
          if (w_v)
            for (int l = 0; l < 4; l++)
              if (strobe[l]) dm[data_adr[9:2]][8*l +: 8] = data_o[8*l +: 8];
          exp_busy += d + 1;
        end
      end
    end
  end

  initial begin : monitor
    resp_t e;
    bit clr;
    clr = 1'b0;
    forever begin
      @(negedge clk);
      if (clr) begin
        clr = 1'b0;
        check("resp_v one cycle", {31'h0, resp_v}, 32'h0);
        check("resp_data cleared", resp_data, 32'h0);
        check("misalign_err cleared", {31'h0, misalign_err}, 32'h0);
      end else if (resp_v) begin
        clr = 1'b1;
        if (exp_resp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected resp_v: resp_data %h, required no response", resp_data);
        end else begin
          e = exp_resp.pop_front();
          check("resp_data", resp_data, e.data);
          check("misalign_err", {31'h0, misalign_err}, {31'h0, e.err});
          check("latency", 32'(cyc - acc_cyc), 32'(1 + exp_busy));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    for (int w = 0; w < 256; w++) poke(w, $urandom);
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready after reset", {31'h0, req_ready}, 32'h1);
    poke(32'h100 >> 2, 32'h80FF7F01);
    issue(1'b0, 32'h103, 2'd0, 1'b0, 32'h0);
    issue(1'b0, 32'h103, 2'd0, 1'b1, 32'h0);
    drain();
    force_delay = 2;
    issue(1'b1, 32'h206, 2'd1, 1'b0, 32'h1234BEEF);
    drain();
    force_delay = -1;
    issue(1'b1, 32'h40, 2'd2, 1'b0, 32'hDEADBEEF);
    issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
    issue(1'b0, 32'h42, 2'd2, 1'b0, 32'h0);
    drain();
    poke(32'h40 >> 2, 32'h44332211);
    poke(32'h44 >> 2, 32'h88776655);
    issue(1'b0, 32'h43, 2'd2, 1'b0, 32'h0);
    issue(1'b1, 32'h0, 2'd3, 1'b0, 32'h12345678);
    issue(1'b0, 32'h0, 2'd2, 1'b1, 32'h0);
    drain();
    hold_ack = 1'b1;
    issue(1'b0, 32'h80, 2'd2, 1'b0, 32'h0);
    check("r_v in access", {31'h0, r_v}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_quiet("async reset");
    repeat (3) begin
      @(negedge clk);
      check_quiet("in reset");
    end
    exp_resp.delete();
    exp_beat.delete();
    hold_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready after abort", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    spurious = 1'b1;
    repeat (2) @(negedge clk);
    spurious = 1'b0;
    @(negedge clk);
    check("ready after stray ack", {31'h0, req_ready}, 32'h1);
    check("no bus after stray ack", {30'h0, r_v, w_v}, 32'h0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 200; i++)
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h3F0)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_dmem_port.md
Name: lsu_dmem_port

Overview:
- Load/store unit between the CPU memory stage and the data memory (basic_mem dmem instance). It sits directly downstream of the CPU mem stage and directly upstream of dmem.
- Accepts one byte/half/word load or store request at a time.
- Produces word-aligned bus transactions: r_v/w_v, adr, data, strobe. Waits for ack.
- Returns load data aligned and sign- or zero-extended, and flags misaligned accesses.

Parameters:
xlen, 32, data/address width (only 32 supported)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_v  in  1  CPU request valid
req_ready  out  1  LSU can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_adr  in  xlen  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
req_unsigned  in  1  zero-extend load result
req_wdata  in  xlen  store data, right-justified
resp_v  out  1  one-cycle completion pulse (loads and stores)
resp_data  out  xlen  load result; 0 for stores and errors
misalign_err  out  1  valid with resp_v; access was rejected
r_v  out  1  dmem read valid
w_v  out  1  dmem write valid
data_adr  out  xlen  dmem word address, bits [1:0] always 0
data_o  out  xlen  dmem write data, lane-replicated
strobe  out  4  dmem byte enables
dmem_resp  in  xlen  dmem read data
dmem_resp_v  in  1  dmem ack

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - r_v, w_v, resp_v, misalign_err, strobe, data_adr, data_o and resp_data are all 0.
  - req_ready is 1 once rst_n is high.
  - Reset in any state aborts the in-flight transaction with no resp_v pulse.
- States: IDLE, ACCESS, ACCESS2 (only with the optional feature), RESP.
- IDLE:
  - req_ready = 1.
  - req_v && req_ready latches adr, size, we, unsigned and wdata.
  - Aligned or allowed access -> ACCESS. Rejected misaligned access -> RESP with misalign_err set and no bus activity.
- Alignment rule (feature off): half needs adr[0] = 0; word needs adr[1:0] = 0.
- ACCESS:
  - Drive r_v = !we, w_v = we, data_adr = {adr[31:2], 2'b00}, strobe and data_o.
  - Hold all bus outputs stable until dmem_resp_v is sampled high, then go to RESP (or ACCESS2).
  - Bus outputs drop to 0 the cycle after ack.
- Strobe:
  - byte: 4'b0001 << adr[1:0]
  - half: 4'b0011 << adr[1:0]
  - word: 4'b1111
- data_o:
  - byte: wdata[7:0] replicated to 4 lanes
  - half: wdata[15:0] replicated to 2 halves
  - word: wdata unchanged
- Load extraction:
  - Shift dmem_resp right by 8*adr[1:0] and take the low 8/16/32 bits.
  - Sign-extend from bit 7/15 unless req_unsigned. Word ignores req_unsigned.
  - Result is registered into resp_data on the ack cycle.
- RESP:
  - resp_v = 1 for exactly one cycle, then IDLE.
  - Minimum latency from request acceptance to resp_v is 2 cycles when ack arrives the first ACCESS cycle; each extra wait cycle adds 1.
  - Minimum request-to-request spacing is 3 cycles.
- Boundary cases:
  - dmem_resp_v in IDLE or RESP is ignored.
  - req_v while req_ready = 0 is ignored; the CPU must hold the request.
  - Store to address 0 is an ordinary store; exit detection happens elsewhere.
  - resp_data and misalign_err are cleared to 0 on the cycle after resp_v.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN
- When defined:
  - An access is split only when adr[1:0] + bytes > 4. Other unaligned half/word accesses (e.g. half at offset 1) complete in a single ACCESS.
  - ACCESS handles word adr & ~3 with upper lanes: strobe = 4'b1111 << adr[1:0] masked to the access size.
  - ACCESS2 handles word (adr & ~3) + 4 with the remaining lower lanes.
  - Store data is rotated left by 8*adr[1:0] across both beats.
  - Load bytes are merged from both beats before extension.
  - misalign_err is never asserted.
- When undefined: the natural-alignment rule applies, misaligned accesses are rejected, and ACCESS2 does not exist.

Test Plan:
- Reset: rst_n low for 3 cycles mid-ACCESS, then release -> bus outputs 0 during reset, req_ready = 1 afterwards, no resp_v.
- Signed byte load: dmem word at 0x100 = 0x80FF7F01, load byte adr 0x103 signed -> strobe 4'b1000, data_adr 0x100, resp_data 0xFFFFFF80; same load unsigned -> 0x00000080.
- Half store: store half 0xBEEF at adr 0x206 with ack delayed 2 cycles -> w_v held 3 cycles, strobe 4'b1100, data_o 0xBEEFBEEF, resp_v 1 cycle after ack.
- Word round trip: store 0xDEADBEEF to 0x40, then load word 0x40 -> resp_data 0xDEADBEEF, misalign_err 0.
- Misaligned word (feature off): load word adr 0x42 -> no r_v, resp_v and misalign_err next-next cycle, resp_data 0.
- Split load (feature on): words 0x40 = 0x44332211 and 0x44 = 0x88776655, load word adr 0x43 -> two reads (strobe 4'b1000, then 4'b0111), resp_data 0x77665544, misalign_err 0.
